// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan block: segment patterns
// (segA..segG, active-low) and the scan FSM state encoding.
package sev_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/sev_seg.sv
// Combinational BCD to seven-segment decoder (active-low, segA in bit 6).
// Non-BCD codes 10..15 produce an unlit digit.
module sev_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed seven-segment scanner with blanked slot starts and
// frame-synchronous double-buffered data. SEV_SEG_SCAN_LZB_EN adds leading-zero blanking.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST       = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    upd_q, upd_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic       slot_end, boundary;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg, disp_seg;

  assign cur_digit = active_q[{idx_q, 2'b00} +: 4];

  sev_seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef SEV_SEG_SCAN_LZB_EN
  // A digit is a leading zero when it and every higher digit are zero.
  logic lead_zero;
  assign lead_zero = (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
  assign disp_seg  = lead_zero ? SEG_BLANK : dec_seg;
`else
  assign disp_seg  = dec_seg;
`endif

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pending_d    = pending_q;
    upd_d        = upd_q;
    seg_d        = SEG_BLANK;
    an_d         = '1;
    frame_done_d = boundary;

    if (slot_end) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
      idx_d   = boundary ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_BLANK_LAST) state_d = ST_SHOW;
    end

    // Active only changes on the frame boundary, so no frame ever tears.
    if (boundary) begin
      if (load) begin
        active_d = digits;
        upd_d    = 1'b0;
      end else if (upd_q) begin
        active_d = pending_q;
        upd_d    = 1'b0;
      end
    end else if (load) begin
      pending_d = digits;
      upd_d     = 1'b1;
    end

    if (state_q == ST_SHOW) begin
      seg_d = disp_seg;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      upd_q        <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      upd_q        <= upd_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg            = seg_q;
  assign an             = an_q;
  assign update_pending = upd_q;
  assign frame_done     = frame_done_q;

endmodule
